plic_claim_agent: RTL and testbench
===================================

// Module: plic_claim_agent
// PURPOSE
//   Hart-side APB initiator that services the PLIC external interrupt. On ext_irq_i it
//   reads CLAIMCOMP (BASE_ADDR+0x20), hands the claimed ID to the core over a valid/ready
//   handshake, waits for the core's done strobe, then writes the ID back to CLAIMCOMP.
//   Sits between the PLIC APB slave and the core's interrupt entry logic.
// PARAMETERS
//   BASE_ADDR    32'h0000_0000  PLIC base address; claim/complete at BASE_ADDR+32'h20
//   ID_WIDTH     5              claim ID width, equal to the PLIC CLAIMCOMP width
//   HOLDOFF_CYC  2              idle cycles after a complete write before ext_irq_i is resampled
// PORTS
//   pclk         in   1         clock
//   presetn      in   1         synchronous active-low reset
//   en_i         in   1         agent enable; sampled only in IDLE
//   ext_irq_i    in   1         PLIC ext_irq_o
//   paddr_o      out  32        APB address
//   pprot_o      out  3         APB protection, constant 3'b000
//   psel_o       out  1         APB select
//   penable_o    out  1         APB enable
//   pwrite_o     out  1         APB write (1) / read (0)
//   pwdata_o     out  32        APB write data {(32-ID_WIDTH)'0, id}
//   pstrb_o      out  4         APB strobes: 4'hF on write, 4'h0 on read
//   pready_i     in   1         APB ready
//   pslverr_i    in   1         APB error
//   prdata_i     in   32        APB read data; only [ID_WIDTH-1:0] used
//   irq_valid_o  out  1         claimed ID presented to core
//   irq_id_o     out  ID_WIDTH  claimed ID, stable while irq_valid_o=1
//   irq_ready_i  in   1         core accepts ID
//   irq_done_i   in   1         core handler finished; completion may be issued
//   busy_o       out  1         FSM not in IDLE
//   spurious_o   out  1         1-cycle pulse: claim returned ID 0
//   err_o        out  1         1-cycle pulse: pslverr_i seen on a completing transfer
// BEHAVIOUR
//   Reset: FSM=IDLE; psel_o, penable_o, pwrite_o, irq_valid_o, busy_o, spurious_o, err_o=0;
//     paddr_o=BASE_ADDR+32'h20; pwdata_o, pstrb_o, irq_id_o=0; holdoff counter=0.
//   States: IDLE, RD_SETUP, RD_ACCESS, PRESENT, SERVICE, WR_SETUP, WR_ACCESS, HOLDOFF.
//   IDLE: en_i & ext_irq_i -> RD_SETUP next cycle.
//   RD_SETUP: psel=1, penable=0, pwrite=0, pstrb=0 -> RD_ACCESS unconditionally.
//   RD_ACCESS: psel=1, penable=1; hold until pready_i. On pready_i:
//     pslverr_i=1 -> err_o pulse, IDLE; else id=prdata_i[ID_WIDTH-1:0] latched into irq_id_o;
//     id==0 -> spurious_o pulse, IDLE (no complete write); else PRESENT.
//   PRESENT: irq_valid_o=1; on irq_valid_o & irq_ready_i -> SERVICE (valid drops next cycle).
//   SERVICE: wait irq_done_i; done asserted in the same cycle as acceptance is ignored
//     (only sampled in SERVICE) -> WR_SETUP.
//   WR_SETUP: psel=1, penable=0, pwrite=1, pstrb=4'hF, pwdata={0,irq_id_o} -> WR_ACCESS.
//   WR_ACCESS: psel=1, penable=1; hold until pready_i; then err_o pulse if pslverr_i;
//     -> HOLDOFF either way (ID is considered completed).
//   HOLDOFF: counts HOLDOFF_CYC cycles then IDLE; HOLDOFF_CYC=0 goes straight to IDLE.
//   APB signals are registered; all address/data/control stable from SETUP through ACCESS.
//   Latency: ext_irq_i high in IDLE -> psel_o high 1 cycle later; zero-wait read ->
//     irq_valid_o high 3 cycles after ext_irq_i sampled.
//   ext_irq_i deasserting after IDLE has no effect; transaction runs to completion.
//   en_i deasserting mid-operation has no effect until return to IDLE.
//   Reset mid-transfer: outputs return to reset values next edge; transfer abandoned,
//     no complete write issued; the PLIC-side claim is left to software recovery.
//   busy_o = (state != IDLE), registered with the state.
// TESTING
//   ext_irq_i=1, prdata=32'h5, zero-wait -> read @BASE+0x20, irq_id_o=5, irq_ready/done ->
//     write pwdata=32'h5, pstrb=4'hF, then 2 HOLDOFF cycles, IDLE.
//   Claim read with 3 pready_i wait cycles -> psel/penable/paddr held stable, id latched on ready.
//   prdata=32'h0 -> spurious_o pulse, no write transfer, IDLE; prdata=32'hFFFF_FFF3 -> id=19.
//   pslverr_i=1 on claim read -> err_o 1-cycle pulse, irq_valid_o never rises, IDLE.
//   irq_done_i held 1 before acceptance -> completion write only after SERVICE entered.
//   presetn=0 during RD_ACCESS -> psel_o/penable_o=0 next cycle, no write, IDLE; en_i=0 blocks claim.

Source files
------------

// File: rtl/plic_claim_agent.sv
// plic_claim_agent: APB initiator that claims a PLIC interrupt, hands the ID to the core and completes it.
module plic_claim_agent #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ID_WIDTH    = 5,
  parameter int          HOLDOFF_CYC = 2
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                en_i,
  input  logic                ext_irq_i,
  output logic [31:0]         paddr_o,
  output logic [2:0]          pprot_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [31:0]         pwdata_o,
  output logic [3:0]          pstrb_o,
  input  logic                pready_i,
  input  logic                pslverr_i,
  input  logic [31:0]         prdata_i,
  output logic                irq_valid_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ready_i,
  input  logic                irq_done_i,
  output logic                busy_o,
  output logic                spurious_o,
  output logic                err_o
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_SETUP  = 3'd1;
  localparam logic [2:0] RD_ACCESS = 3'd2;
  localparam logic [2:0] PRESENT   = 3'd3;
  localparam logic [2:0] SERVICE   = 3'd4;
  localparam logic [2:0] WR_SETUP  = 3'd5;
  localparam logic [2:0] WR_ACCESS = 3'd6;
  localparam logic [2:0] HOLDOFF   = 3'd7;
  localparam int CW = HOLDOFF_CYC > 1 ? $clog2(HOLDOFF_CYC) : 1;
  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [ID_WIDTH-1:0] rd_id;
  logic                unused_prdata;
  assign rd_id         = prdata_i[ID_WIDTH-1:0];
  assign unused_prdata = ^prdata_i[31:ID_WIDTH];
  assign paddr_o       = BASE_ADDR + 32'h20;
  assign pprot_o       = 3'b000;
  assign busy_o        = state != IDLE;
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      cnt         <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= 4'h0;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      spurious_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      spurious_o <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        IDLE: if (en_i && ext_irq_i) begin
          state    <= RD_SETUP;
          psel_o   <= 1'b1;
          pwrite_o <= 1'b0;
          pstrb_o  <= 4'h0;
        end
        RD_SETUP: begin
          state     <= RD_ACCESS;
          penable_o <= 1'b1;
        end
        RD_ACCESS: if (pready_i) begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          if (pslverr_i) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            irq_id_o    <= rd_id;
            spurious_o  <= rd_id == '0;
            irq_valid_o <= rd_id != '0;
            state       <= rd_id == '0 ? IDLE : PRESENT;
          end
        end
        PRESENT: if (irq_ready_i) begin
          irq_valid_o <= 1'b0;
          state       <= SERVICE;
        end
        // done is only honoured once the ID has been accepted
        SERVICE: if (irq_done_i) begin
          state    <= WR_SETUP;
          psel_o   <= 1'b1;
          pwrite_o <= 1'b1;
          pstrb_o  <= 4'hF;
          pwdata_o <= {{(32-ID_WIDTH){1'b0}}, irq_id_o};
        end
        WR_SETUP: begin
          state     <= WR_ACCESS;
          penable_o <= 1'b1;
        end
        WR_ACCESS: if (pready_i) begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          pwrite_o  <= 1'b0;
          pstrb_o   <= 4'h0;
          err_o     <= pslverr_i;
          cnt       <= '0;
          state     <= HOLDOFF_CYC == 0 ? IDLE : HOLDOFF;
        end
        default: begin
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(HOLDOFF_CYC - 1) ? IDLE : HOLDOFF;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plic_claim_agent.sv
// tb_plic_claim_agent: directed and randomized claim/complete transactions against a rule-based model.
module tb_plic_claim_agent;
  logic        clk = 1'b0;
  logic        presetn, en_i, ext_irq_i, pready_i, pslverr_i, irq_ready_i, irq_done_i;
  logic [31:0] prdata_i, paddr_o, pwdata_o;
  logic [2:0]  pprot_o;
  logic [3:0]  pstrb_o;
  logic        psel_o, penable_o, pwrite_o, irq_valid_o, busy_o, spurious_o, err_o;
  logic [4:0]  irq_id_o;
  int          tests = 0;
  int          fails = 0;
  always #5 clk = ~clk;
  plic_claim_agent dut (
    .pclk(clk), .presetn(presetn), .en_i(en_i), .ext_irq_i(ext_irq_i),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .prdata_i(prdata_i), .irq_valid_o(irq_valid_o),
    .irq_id_o(irq_id_o), .irq_ready_i(irq_ready_i), .irq_done_i(irq_done_i),
    .busy_o(busy_o), .spurious_o(spurious_o), .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apb_chk(input string tag, input bit sel, input bit en, input bit wr, input logic [3:0] strb);
    chk({tag, ".psel"}, 32'(psel_o), 32'(sel));
    chk({tag, ".penable"}, 32'(penable_o), 32'(en));
    if (sel) begin
      chk({tag, ".pwrite"}, 32'(pwrite_o), 32'(wr));
      chk({tag, ".pstrb"}, 32'(pstrb_o), 32'(strb));
      chk({tag, ".paddr"}, paddr_o, 32'h20);
    end
  endtask
  // One claim/complete episode; expectations follow from the protocol rules alone.
  task automatic txn(input logic [31:0] rd, input int rw, input bit rerr, input int ww,
                     input bit werr, input int rdly, input int ddly, input bit early);
    logic [4:0] id;
    id = rd[4:0];
    en_i = 1'b1;
    ext_irq_i = 1'b1;
    irq_done_i = early;
    step();
    ext_irq_i = 1'b0;
    apb_chk("rd_setup", 1, 0, 0, 4'h0);
    chk("rd_setup.busy", 32'(busy_o), 1);
    step();
    for (int i = 0; i < rw; i++) begin
      apb_chk("rd_wait", 1, 1, 0, 4'h0);
      prdata_i = $urandom;
      step();
    end
    apb_chk("rd_access", 1, 1, 0, 4'h0);
    pready_i = 1'b1;
    pslverr_i = rerr;
    prdata_i = rd;
    step();
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    prdata_i = $urandom;
    apb_chk("rd_done", 0, 0, 0, 4'h0);
    if (rerr) begin
      chk("rd_err.err", 32'(err_o), 1);
      chk("rd_err.valid", 32'(irq_valid_o), 0);
      chk("rd_err.busy", 32'(busy_o), 0);
      step();
      chk("rd_err.pulse", 32'(err_o), 0);
      chk("rd_err.valid2", 32'(irq_valid_o), 0);
      irq_done_i = 1'b0;
      return;
    end
    chk("rd.err", 32'(err_o), 0);
    if (id == 0) begin
      chk("spur.pulse", 32'(spurious_o), 1);
      chk("spur.busy", 32'(busy_o), 0);
      chk("spur.valid", 32'(irq_valid_o), 0);
      step();
      chk("spur.pulse_end", 32'(spurious_o), 0);
      chk("spur.nowrite", 32'(psel_o), 0);
      irq_done_i = 1'b0;
      return;
    end
    chk("present.valid", 32'(irq_valid_o), 1);
    chk("present.id", 32'(irq_id_o), 32'(id));
    chk("present.spur", 32'(spurious_o), 0);
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("present.hold", 32'(irq_valid_o), 1);
      chk("present.id_stable", 32'(irq_id_o), 32'(id));
      chk("present.nowrite", 32'(psel_o), 0);
    end
    irq_ready_i = 1'b1;
    step();
    irq_ready_i = 1'b0;
    chk("service.valid", 32'(irq_valid_o), 0);
    chk("service.early_ignored", 32'(psel_o), 0);
    chk("service.busy", 32'(busy_o), 1);
    irq_done_i = ddly == 0;
    for (int i = 0; i < ddly; i++) begin
      step();
      chk("service.wait", 32'(psel_o), 0);
      irq_done_i = i == ddly - 1;
    end
    step();
    irq_done_i = 1'b0;
    apb_chk("wr_setup", 1, 0, 1, 4'hF);
    chk("wr_setup.pwdata", pwdata_o, 32'(id));
    step();
    for (int i = 0; i < ww; i++) begin
      apb_chk("wr_wait", 1, 1, 1, 4'hF);
      chk("wr_wait.pwdata", pwdata_o, 32'(id));
      step();
    end
    apb_chk("wr_access", 1, 1, 1, 4'hF);
    chk("wr_access.pwdata", pwdata_o, 32'(id));
    pready_i = 1'b1;
    pslverr_i = werr;
    step();
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    apb_chk("wr_done", 0, 0, 0, 4'h0);
    chk("wr_done.err", 32'(err_o), 32'(werr));
    chk("holdoff1.busy", 32'(busy_o), 1);
    ext_irq_i = 1'b1;
    step();
    chk("holdoff2.busy", 32'(busy_o), 1);
    chk("holdoff2.err_pulse", 32'(err_o), 0);
    chk("holdoff2.ignore_irq", 32'(psel_o), 0);
    step();
    ext_irq_i = 1'b0;
    chk("idle.busy", 32'(busy_o), 0);
    chk("idle.psel", 32'(psel_o), 0);
  endtask
  initial begin
    presetn = 1'b0; en_i = 1'b0; ext_irq_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
    prdata_i = '0; irq_ready_i = 1'b0; irq_done_i = 1'b0;
    step();
    step();
    chk("reset.psel", 32'(psel_o), 0);
    chk("reset.penable", 32'(penable_o), 0);
    chk("reset.pwrite", 32'(pwrite_o), 0);
    chk("reset.paddr", paddr_o, 32'h20);
    chk("reset.pprot", 32'(pprot_o), 0);
    chk("reset.pwdata", pwdata_o, 0);
    chk("reset.pstrb", 32'(pstrb_o), 0);
    chk("reset.valid", 32'(irq_valid_o), 0);
    chk("reset.id", 32'(irq_id_o), 0);
    chk("reset.busy", 32'(busy_o), 0);
    chk("reset.spur", 32'(spurious_o), 0);
    chk("reset.err", 32'(err_o), 0);
    presetn = 1'b1;
    step();
    txn(32'h5, 0, 0, 0, 0, 0, 0, 0);
    txn(32'h9, 3, 0, 1, 0, 2, 1, 0);
    txn(32'h0, 1, 0, 0, 0, 0, 0, 0);
    txn(32'hFFFF_FFF3, 0, 0, 0, 0, 0, 0, 0);
    chk("id19", 32'(irq_id_o), 19);
    txn(32'h7, 2, 1, 0, 0, 0, 0, 0);
    txn(32'h1F, 0, 0, 0, 0, 1, 0, 1);
    txn(32'h1F, 0, 0, 0, 0, 0, 2, 1);
    txn(32'h3, 0, 0, 2, 1, 0, 0, 0);
    en_i = 1'b1;
    ext_irq_i = 1'b1;
    step();
    step();
    ext_irq_i = 1'b0;
    apb_chk("rst_mid.access", 1, 1, 0, 4'h0);
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    chk("rst_mid.psel", 32'(psel_o), 0);
    chk("rst_mid.penable", 32'(penable_o), 0);
    chk("rst_mid.busy", 32'(busy_o), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid.nowrite", 32'(psel_o), 0);
    end
    en_i = 1'b0;
    ext_irq_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_off.psel", 32'(psel_o), 0);
      chk("en_off.busy", 32'(busy_o), 0);
    end
    ext_irq_i = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] rd;
      rd = $urandom;
      if ($urandom_range(0, 5) == 0) rd[4:0] = 5'd0;
      txn(rd, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 3),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
